read_stage_rr_arbiter_n: RTL and testbench
==========================================

# read_stage_rr_arbiter_n

Parametrised N-way round-robin arbiter for VRF read requests in the lane read stage. It replaces the fixed two-input combinational arbiter. It adds a configurable requester count and a full-throughput 2-entry registered output buffer that decouples `io_out_ready` from the input ready path. It also adds a synchronous flush and carries `groupIndex` through to the output. It sits between the per-slot read request sources and the VRF read port.

## Interface
Parameters:
- `NUM_IN`, default 4: number of requesters, ≥2.
- `VS_W`, default 5: vs field width.
- `OFFSET_W`, default 2: offset field width.
- `GROUP_W`, default 4: groupIndex field width.
- `SRC_W`, default 4: readSource field width.
- `IDX_W`, default 3: instructionIndex field width.
- `PTR_W` is derived as clog2(`NUM_IN`) and is not user-settable.

Ports (clock and reset first):
- `clock`, in, 1: sole clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-low (0 = reset).
- `io_flush`, in, 1: synchronously drops all buffered entries.
- `io_in_valid`, in, `NUM_IN`: per-requester valid.
- `io_in_ready`, out, `NUM_IN`: per-requester ready; at most one bit set.
- `io_in_bits_vs`, in, `NUM_IN*VS_W`: requester i occupies slice [i*VS_W +: VS_W]. The other packed fields below use the same slicing.
- `io_in_bits_offset`, in, `NUM_IN*OFFSET_W`
- `io_in_bits_groupIndex`, in, `NUM_IN*GROUP_W`
- `io_in_bits_readSource`, in, `NUM_IN*SRC_W`
- `io_in_bits_instructionIndex`, in, `NUM_IN*IDX_W`
- `io_out_ready`, in, 1: downstream ready.
- `io_out_valid`, out, 1: buffer head valid.
- `io_out_bits_vs`, out, `VS_W`
- `io_out_bits_offset`, out, `OFFSET_W`
- `io_out_bits_groupIndex`, out, `GROUP_W`
- `io_out_bits_readSource`, out, `SRC_W`
- `io_out_bits_instructionIndex`, out, `IDX_W`

## Operation
- **Round-robin state**
  - `lastGrant`, `PTR_W` bits; reset value `NUM_IN-1`, so requester 0 has top priority after reset.
- **Grant**
  - Scan from (`lastGrant`+1) mod `NUM_IN` upward with wrap-around.
  - The first requester with `io_in_valid` set wins. The grant is combinational on valids and `lastGrant`, and is one-hot or zero.
- **Accept**
  - `io_in_ready[i]` = grant[i] & (count < 2) & ~`io_flush` & `reset`.
  - A transfer on requester i requires `io_in_valid[i]` & `io_in_ready[i]`.
  - Non-granted requesters see ready 0 and must hold their request (standard valid/ready; valid must not drop before transfer).
- **Pointer update**
  - On accept only, `lastGrant` ← granted index.
  - No update when nothing is accepted. This includes a full buffer and flush cycles.
- **Buffer**
  - 2-entry FIFO holding {vs, offset, groupIndex, readSource, instructionIndex}, with count in 0..2.
  - Push on accept; pop on `io_out_valid` & `io_out_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - At count 2 there is no push, even when a pop occurs that cycle; the accept path does not bypass a full buffer.
- **Output**
  - `io_out_valid` = (count ≠ 0). Out bits come from the head entry.
  - All out bits are driven 0 when count = 0.
- **Flush**
  - When `io_flush` = 1: count ← 0 and pointers ← 0, no accept, and no pop is counted. `lastGrant` is unchanged.
  - If flush and reset are both active, reset wins; the result is identical.
- **Reset (reset = 0)**
  - count = 0, `io_out_valid` = 0, all `io_in_ready` = 0, out bits = 0, `lastGrant` = `NUM_IN-1`.
  - Reset mid-transfer discards buffered entries without emitting them.

## Timing
- Latency: an input accepted in cycle t appears at the output with `io_out_valid` = 1 in cycle t+1.
- Throughput: 1 request/cycle sustained while `io_out_ready` = 1 (count stays at 1).
- Backpressure: after `io_out_ready` drops, at most 2 further requests are accepted. Input ready then stays 0 until a pop frees an entry, and accepting resumes the cycle after that pop.
- `io_in_ready` depends combinationally on `io_in_valid`, registered count, `io_flush` and `reset`. It never depends on `io_out_ready`.
- Out bits and `io_out_valid` come only from registers; there is no combinational input→output path.

## Test plan
- **Reset**: hold `reset` = 0 for 3 cycles with all valids high → `io_in_ready` = 0 and `io_out_valid` = 0. Release `reset` with all 4 valid → first grant to 0, then 1, 2, 3, 0 on successive cycles. Outputs appear one cycle later in the same order.
- **Fairness with gaps**: `NUM_IN` = 4, only requesters 1 and 3 valid, `io_out_ready` = 1 → grants alternate 1, 3, 1, 3. Then add requester 2 after a grant to 3 → next grant goes to 1, then 2.
- **Backpressure**: `io_out_ready` = 0 with requester 0 valid, vs = 5'h0A then 5'h0B then 5'h0C → two accepts, then ready 0. Raise `io_out_ready` → output 0A, then 0B; 0C is accepted the cycle after the first pop. No data is lost or duplicated.
- **Full-buffer simultaneous pop**: at count 2 assert `io_out_ready` with a requester valid → no accept that cycle; count goes to 1 and the accept happens the next cycle.
- **Flush**: count = 2, assert `io_flush` for 1 cycle with valids high → ready 0 that cycle; next cycle `io_out_valid` = 0 and out bits = 0. `lastGrant` is preserved, so the next grant follows the prior order.
- **Field routing**: distinct per-requester values, including `groupIndex` = 4'hF on requester 2 only → output fields match the granted requester exactly.

Source files
------------

// File: rtl/read_stage_rr_arbiter_n.sv
// N-way round-robin arbiter for VRF read requests with a 2-entry registered
// output buffer, synchronous flush and synchronous active-low reset.
module read_stage_rr_arbiter_n #(
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned VS_W     = 5,
  parameter int unsigned OFFSET_W = 2,
  parameter int unsigned GROUP_W  = 4,
  parameter int unsigned SRC_W    = 4,
  parameter int unsigned IDX_W    = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        io_flush,
  input  logic [NUM_IN-1:0]           io_in_valid,
  output logic [NUM_IN-1:0]           io_in_ready,
  input  logic [NUM_IN*VS_W-1:0]      io_in_bits_vs,
  input  logic [NUM_IN*OFFSET_W-1:0]  io_in_bits_offset,
  input  logic [NUM_IN*GROUP_W-1:0]   io_in_bits_groupIndex,
  input  logic [NUM_IN*SRC_W-1:0]     io_in_bits_readSource,
  input  logic [NUM_IN*IDX_W-1:0]     io_in_bits_instructionIndex,
  input  logic                        io_out_ready,
  output logic                        io_out_valid,
  output logic [VS_W-1:0]             io_out_bits_vs,
  output logic [OFFSET_W-1:0]         io_out_bits_offset,
  output logic [GROUP_W-1:0]          io_out_bits_groupIndex,
  output logic [SRC_W-1:0]            io_out_bits_readSource,
  output logic [IDX_W-1:0]            io_out_bits_instructionIndex
);

  localparam int unsigned PTR_W   = $clog2(NUM_IN);
  localparam int unsigned ENTRY_W = VS_W + OFFSET_W + GROUP_W + SRC_W + IDX_W;

  logic [PTR_W-1:0]   last_grant_q;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   scan_idx;
  logic [NUM_IN-1:0]  grant;
  logic               found;
  logic [1:0]         count_q, count_d;
  logic               wr_ptr_q, rd_ptr_q;
  logic [ENTRY_W-1:0] mem_q [2];
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head;
  logic               can_accept;
  logic               push;
  logic               pop;

  // Round-robin scan starting one past the last accepted requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    scan_idx  = '0;
    found     = 1'b0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      scan_idx = PTR_W'((32'(last_grant_q) + k) % NUM_IN);
      if (!found && io_in_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  // Select the granted requester's fields into one buffer entry.
  always_comb begin
    in_entry = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (grant[i]) begin
        in_entry = {io_in_bits_vs[i*VS_W +: VS_W],
                    io_in_bits_offset[i*OFFSET_W +: OFFSET_W],
                    io_in_bits_groupIndex[i*GROUP_W +: GROUP_W],
                    io_in_bits_readSource[i*SRC_W +: SRC_W],
                    io_in_bits_instructionIndex[i*IDX_W +: IDX_W]};
      end
    end
  end

  // Ready never looks at io_out_ready: a full buffer blocks even if it pops.
  assign can_accept  = (count_q != 2'd2) && !io_flush && reset;
  assign io_in_ready = grant & {NUM_IN{can_accept}};
  assign push        = |(io_in_valid & io_in_ready);
  assign pop         = io_out_valid && io_out_ready && !io_flush;

  // Occupancy next state.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  // Control state: occupancy, FIFO pointers and round-robin pointer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q      <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      last_grant_q <= PTR_W'(NUM_IN - 1);
    end else if (io_flush) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q     <= ~wr_ptr_q;
        last_grant_q <= grant_idx;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Payload storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  assign head         = mem_q[rd_ptr_q];
  assign io_out_valid = (count_q != 2'd0);

  // Head entry drives the outputs; zeroed while the buffer is empty.
  always_comb begin
    io_out_bits_vs               = '0;
    io_out_bits_offset           = '0;
    io_out_bits_groupIndex       = '0;
    io_out_bits_readSource       = '0;
    io_out_bits_instructionIndex = '0;
    if (io_out_valid) begin
      {io_out_bits_vs, io_out_bits_offset, io_out_bits_groupIndex,
       io_out_bits_readSource, io_out_bits_instructionIndex} = head;
    end
  end

endmodule

// File: tb/tb_read_stage_rr_arbiter_n.sv
// Directed bench: a cycle-by-cycle vector table plus a field-routing sequence.
module tb_read_stage_rr_arbiter_n;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_flush;
  logic [3:0]  io_in_valid;
  logic [3:0]  io_in_ready;
  logic [19:0] io_in_bits_vs;
  logic [7:0]  io_in_bits_offset;
  logic [15:0] io_in_bits_groupIndex;
  logic [15:0] io_in_bits_readSource;
  logic [11:0] io_in_bits_instructionIndex;
  logic        io_out_ready;
  logic        io_out_valid;
  logic [4:0]  io_out_bits_vs;
  logic [1:0]  io_out_bits_offset;
  logic [3:0]  io_out_bits_groupIndex;
  logic [3:0]  io_out_bits_readSource;
  logic [2:0]  io_out_bits_instructionIndex;

  int errors = 0;
  int checks = 0;

  read_stage_rr_arbiter_n dut (
    .clock                       (clock),
    .reset                       (reset),
    .io_flush                    (io_flush),
    .io_in_valid                 (io_in_valid),
    .io_in_ready                 (io_in_ready),
    .io_in_bits_vs               (io_in_bits_vs),
    .io_in_bits_offset           (io_in_bits_offset),
    .io_in_bits_groupIndex       (io_in_bits_groupIndex),
    .io_in_bits_readSource       (io_in_bits_readSource),
    .io_in_bits_instructionIndex (io_in_bits_instructionIndex),
    .io_out_ready                (io_out_ready),
    .io_out_valid                (io_out_valid),
    .io_out_bits_vs              (io_out_bits_vs),
    .io_out_bits_offset          (io_out_bits_offset),
    .io_out_bits_groupIndex      (io_out_bits_groupIndex),
    .io_out_bits_readSource      (io_out_bits_readSource),
    .io_out_bits_instructionIndex (io_out_bits_instructionIndex)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       flush;
    logic [3:0] valid;
    logic       ordy;
    logic [4:0] vs0;
    logic [3:0] exp_ready;
    logic       exp_ovalid;
    logic [4:0] exp_ovs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic flush, logic [3:0] valid, logic ordy,
                              logic [4:0] vs0, logic [3:0] er, logic eov, logic [4:0] eovs);
    vec_t v;
    v.rst = rst; v.flush = flush; v.valid = valid; v.ordy = ordy; v.vs0 = vs0;
    v.exp_ready = er; v.exp_ovalid = eov; v.exp_ovs = eovs;
    return v;
  endfunction

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  initial begin
    // Requester i: vs 0x10+i (req0 from table), offset i, group i (req2 = F),
    // readSource 8+i, instructionIndex i+1.
    reset = 1'b0; io_flush = 1'b0; io_in_valid = '0; io_out_ready = 1'b1;
    io_in_bits_vs               = {5'h13, 5'h12, 5'h11, 5'h10};
    io_in_bits_offset           = {2'd3, 2'd2, 2'd1, 2'd0};
    io_in_bits_groupIndex       = {4'h3, 4'hF, 4'h1, 4'h0};
    io_in_bits_readSource       = {4'hB, 4'hA, 4'h9, 4'h8};
    io_in_bits_instructionIndex = {3'd4, 3'd3, 3'd2, 3'd1};

    //                rst fl valid  ordy vs0    ready  ov  ovs
    // Reset held with all valids high.
    vecs.push_back(mk(0, 0, 4'hF, 1, 5'h10, 4'h0, 0, 5'h00));
    vecs.push_back(mk(0, 0, 4'hF, 1, 5'h10, 4'h0, 0, 5'h00));
    vecs.push_back(mk(0, 0, 4'hF, 1, 5'h10, 4'h0, 0, 5'h00));
    // Release: grants 0,1,2,3,0, outputs one cycle later.
    vecs.push_back(mk(1, 0, 4'hF, 1, 5'h10, 4'h1, 0, 5'h00));
    vecs.push_back(mk(1, 0, 4'hF, 1, 5'h10, 4'h2, 1, 5'h10));
    vecs.push_back(mk(1, 0, 4'hF, 1, 5'h10, 4'h4, 1, 5'h11));
    vecs.push_back(mk(1, 0, 4'hF, 1, 5'h10, 4'h8, 1, 5'h12));
    vecs.push_back(mk(1, 0, 4'hF, 1, 5'h10, 4'h1, 1, 5'h13));
    // Gaps: only 1 and 3 valid -> 1,3,1,3; then add 2 -> 1,2.
    vecs.push_back(mk(1, 0, 4'hA, 1, 5'h10, 4'h2, 1, 5'h10));
    vecs.push_back(mk(1, 0, 4'hA, 1, 5'h10, 4'h8, 1, 5'h11));
    vecs.push_back(mk(1, 0, 4'hA, 1, 5'h10, 4'h2, 1, 5'h13));
    vecs.push_back(mk(1, 0, 4'hA, 1, 5'h10, 4'h8, 1, 5'h11));
    vecs.push_back(mk(1, 0, 4'hE, 1, 5'h10, 4'h2, 1, 5'h13));
    vecs.push_back(mk(1, 0, 4'hE, 1, 5'h10, 4'h4, 1, 5'h11));
    vecs.push_back(mk(1, 0, 4'h0, 1, 5'h10, 4'h0, 1, 5'h12));
    vecs.push_back(mk(1, 0, 4'h0, 1, 5'h10, 4'h0, 0, 5'h00));
    // Backpressure: 0A,0B accepted, 0C held; full-buffer pop does not accept.
    vecs.push_back(mk(1, 0, 4'h1, 0, 5'h0A, 4'h1, 0, 5'h00));
    vecs.push_back(mk(1, 0, 4'h1, 0, 5'h0B, 4'h1, 1, 5'h0A));
    vecs.push_back(mk(1, 0, 4'h1, 0, 5'h0C, 4'h0, 1, 5'h0A));
    vecs.push_back(mk(1, 0, 4'h1, 0, 5'h0C, 4'h0, 1, 5'h0A));
    vecs.push_back(mk(1, 0, 4'h1, 1, 5'h0C, 4'h0, 1, 5'h0A));
    vecs.push_back(mk(1, 0, 4'h1, 1, 5'h0C, 4'h1, 1, 5'h0B));
    vecs.push_back(mk(1, 0, 4'h0, 1, 5'h0C, 4'h0, 1, 5'h0C));
    vecs.push_back(mk(1, 0, 4'h0, 1, 5'h0C, 4'h0, 0, 5'h00));
    // Fill to 2, flush, pointer continues from 2 -> 3 -> 0.
    vecs.push_back(mk(1, 0, 4'hF, 0, 5'h10, 4'h2, 0, 5'h00));
    vecs.push_back(mk(1, 0, 4'hF, 0, 5'h10, 4'h4, 1, 5'h11));
    vecs.push_back(mk(1, 1, 4'hF, 0, 5'h10, 4'h0, 1, 5'h11));
    vecs.push_back(mk(1, 0, 4'hF, 1, 5'h10, 4'h8, 0, 5'h00));
    vecs.push_back(mk(1, 0, 4'hF, 1, 5'h10, 4'h1, 1, 5'h13));
    // Reset mid-transfer discards the buffered entry and rewinds the pointer.
    vecs.push_back(mk(0, 0, 4'hF, 0, 5'h10, 4'h0, 1, 5'h10));
    vecs.push_back(mk(1, 0, 4'hF, 0, 5'h10, 4'h1, 0, 5'h00));
    vecs.push_back(mk(1, 0, 4'h0, 1, 5'h10, 4'h0, 1, 5'h10));
    vecs.push_back(mk(1, 0, 4'h0, 1, 5'h10, 4'h0, 0, 5'h00));

    @(posedge clock);
    foreach (vecs[i]) begin
      @(negedge clock);
      reset             = vecs[i].rst;
      io_flush          = vecs[i].flush;
      io_in_valid       = vecs[i].valid;
      io_out_ready      = vecs[i].ordy;
      io_in_bits_vs[4:0] = vecs[i].vs0;
      #1;
      check("in_ready", i, 32'(io_in_ready), 32'(vecs[i].exp_ready));
      check("out_valid", i, 32'(io_out_valid), 32'(vecs[i].exp_ovalid));
      check("out_vs", i, 32'(io_out_bits_vs), 32'(vecs[i].exp_ovs));
    end

    // Field routing: requester 2 (group F), then requester 3.
    @(negedge clock);
    io_in_valid = 4'h4; io_out_ready = 1'b1;
    #1;
    check("route_ready2", 100, 32'(io_in_ready), 32'h4);
    @(negedge clock);
    io_in_valid = 4'h8;
    #1;
    check("route_ready3", 101, 32'(io_in_ready), 32'h8);
    check("route_vs2", 101, 32'(io_out_bits_vs), 32'h12);
    check("route_off2", 101, 32'(io_out_bits_offset), 32'h2);
    check("route_grp2", 101, 32'(io_out_bits_groupIndex), 32'hF);
    check("route_src2", 101, 32'(io_out_bits_readSource), 32'hA);
    check("route_idx2", 101, 32'(io_out_bits_instructionIndex), 32'h3);
    @(negedge clock);
    io_in_valid = 4'h0;
    #1;
    check("route_vs3", 102, 32'(io_out_bits_vs), 32'h13);
    check("route_off3", 102, 32'(io_out_bits_offset), 32'h3);
    check("route_grp3", 102, 32'(io_out_bits_groupIndex), 32'h3);
    check("route_src3", 102, 32'(io_out_bits_readSource), 32'hB);
    check("route_idx3", 102, 32'(io_out_bits_instructionIndex), 32'h4);
    @(negedge clock);
    #1;
    check("route_empty", 103, 32'(io_out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
